usb3_ep_ring: RTL and testbench
===============================

Name: usb3_ep_ring

Overview:
- Parametrised N-deep buffer manager for a USB 3.0 endpoint; successor to the fixed two-buffer endpoint.
- Sits between the protocol layer and the application side: the in side fills and commits buffers, the out side reads and arms (releases) them.
- Single clock domain, so no internal synchronizers and no stretched acks.
- Adds a fill count, full/empty flags, error pulses, and isochronous overwrite-oldest mode.

Parameters:
- NUM_BUF, 4, buffer count; power of 2, ≥2.
- BUF_WORDS, 256, words per buffer; power of 2.
- DATA_W, 32, word width in bits; multiple of 8.
- LEN_W, 11, byte-length width; must hold BUF_WORDS*DATA_W/8.

Ports:
- local_clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- buf_in_addr  in  clog2(BUF_WORDS)  word address within the current write buffer.
- buf_in_data  in  DATA_W  write data.
- buf_in_wren  in  1  write strobe.
- buf_in_ready  out  1  current write buffer is free.
- buf_in_commit  in  1  single-cycle pulse: current write buffer is complete.
- buf_in_commit_len  in  LEN_W  byte count for the commit.
- buf_in_commit_ack  out  1  one-cycle accept pulse.
- buf_in_commit_err  out  1  one-cycle reject pulse (full, non-isoch mode).
- buf_out_addr  in  clog2(BUF_WORDS)  word address within the current read buffer.
- buf_out_q  out  DATA_W  read data, 1-cycle latency.
- buf_out_len  out  LEN_W  byte length of the current read buffer.
- buf_out_hasdata  out  1  ring not empty.
- buf_out_arm  in  1  single-cycle pulse: release the current read buffer.
- buf_out_arm_ack  out  1  one-cycle accept pulse.
- buf_out_arm_err  out  1  one-cycle reject pulse (arm while empty).
- overrun  out  1  one-cycle pulse: isoch commit overwrote the oldest buffer.
- fill_count  out  clog2(NUM_BUF)+1  number of committed buffers.
- mode  in  2  endpoint mode: 0 control, 1 isoch, 2 bulk, 3 interrupt.

Behaviour:
- State is wr_ptr, rd_ptr (each clog2(NUM_BUF) bits, wrapping modulo NUM_BUF), count, and len[NUM_BUF].
- Reset values (async, reset_n=0):
  - pointers=0, count=0, len[]=0.
  - all pulse outputs=0, buf_in_ready=1, buf_out_hasdata=0, buf_out_len=0.
  - Memory contents are not reset.
- Derived outputs:
  - full = (count==NUM_BUF); empty = (count==0).
  - buf_in_ready = ~full. buf_out_hasdata = ~empty.
  - buf_out_len = len[rd_ptr], combinational from registers.
- Memory addressing: write address {wr_ptr, buf_in_addr}, read address {rd_ptr, buf_out_addr}.
  - buf_in_wren while full is ignored, except in isoch mode.
- Commit, sampled on the rising edge where buf_in_commit=1:
  - Not full: len[wr_ptr] ← min(commit_len, BUF_BYTES); wr_ptr+1; count+1; buf_in_commit_ack=1 next cycle.
  - Full and mode≠1: no state change; buf_in_commit_err=1 next cycle.
  - Full and mode=1: write the len, then wr_ptr+1 and rd_ptr+1; count unchanged; ack=1 and overrun=1 next cycle.
- Arm, sampled on the rising edge where buf_out_arm=1:
  - Not empty: rd_ptr+1; count−1; buf_out_arm_ack=1 next cycle.
  - Empty: buf_out_arm_err=1 next cycle; no state change.
- Simultaneous commit and arm in one cycle: evaluate full/empty on pre-cycle count.
  - Both valid: both pointers advance, count unchanged, both acks.
  - Full with arm valid: the commit is also accepted without error or overrun, because the arm frees the slot. Rule: commit acceptance is computed as (~full | arm_valid).
  - Empty with commit valid: the arm is rejected, the commit is accepted.
- Back-to-back commit or arm pulses every cycle are legal; each is evaluated independently.
- Reset asserted mid-transfer discards all buffers; in-flight ack/err pulses are cleared immediately.
- A mode change takes effect on the next commit.

Optional Feature:
- Macro: USB3_EP_RING_STATS_EN.
- When defined:
  - Adds outputs stat_overrun and stat_commit_err and stat_arm_err, each 16 bits.
  - Each counter increments on its corresponding pulse and saturates at 0xFFFF.
  - Input stat_clr (1 bit) zeroes all three counters synchronously; if stat_clr and an increment occur in the same cycle, clear wins.
  - Counters reset to 0.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package usb3_ep_pkg holds:
  - the EP_MODE_CONTROL/ISOCH/BULK/INTERRUPT constants (2'd0..3);
  - a clog2 function;
  - the derived-width localparams.
- One sub-module, usb3_ep_ram: simple dual-port RAM, depth NUM_BUF*BUF_WORDS, width DATA_W, registered read, single clock.

Test Plan:
1. Reset, then 4 commits of len 512, 100, 1024, 0 with NUM_BUF=4 → 4 acks; fill_count=4; buf_in_ready=0; buf_out_len=512; a 5th commit in bulk mode → commit_err, fill_count stays 4.
2. Write word 0x0000_00A5 at addr 3 of buffer 0, commit, read addr 3 → buf_out_q=0x0000_00A5 one cycle after the address is applied.
3. Arm when empty → arm_err=1, rd_ptr unchanged; then commit len 64, arm → arm_ack, fill_count=0.
4. Mode=1, ring full with lens 10/20/30/40, commit len 50 → ack and overrun; buf_out_len=20; fill_count=4.
5. Ring full, commit and arm in the same cycle → both acks, no err, no overrun; fill_count stays 4; both pointers advance; wrap from index 3 to 0 checked.
6. Assert reset_n=0 asynchronously mid-stream with fill_count=3 → fill_count=0 and hasdata=0 immediately, before the next edge; commit_len=2047 then saturates to 1024.

Source files
------------

// File: rtl/usb3_ep_pkg.sv
// Shared definitions for the USB 3.0 endpoint buffer ring: endpoint mode
// codes, a constant-evaluable clog2, default sizes with their derived widths,
// and a saturating counter helper.
// Optional statistics counters are enabled with `define USB3_EP_RING_STATS_EN.
package usb3_ep_pkg;

  localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
  localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
  localparam logic [1:0] EP_MODE_BULK      = 2'd2;
  localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  localparam int NUM_BUF_DEF   = 4;
  localparam int BUF_WORDS_DEF = 256;
  localparam int DATA_W_DEF    = 32;
  localparam int LEN_W_DEF     = 11;

  localparam int PTR_W_DEF     = clog2(NUM_BUF_DEF);
  localparam int ADDR_W_DEF    = clog2(BUF_WORDS_DEF);
  localparam int CNT_W_DEF     = PTR_W_DEF + 1;
  localparam int BUF_BYTES_DEF = BUF_WORDS_DEF * DATA_W_DEF / 8;

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
    if (inc && (value != 16'hFFFF)) return value + 16'd1;
    return value;
  endfunction

endpackage

// File: rtl/usb3_ep_ring_if.sv
// Handshake and data bus between the endpoint ring and its two clients.
// slave: the ring itself; master: the protocol/application side driving it.
interface usb3_ep_ring_if #(
  parameter int NUM_BUF   = 4,
  parameter int BUF_WORDS = 256,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 11
);
  import usb3_ep_pkg::*;

  localparam int ADDR_W = clog2(BUF_WORDS);
  localparam int CNT_W  = clog2(NUM_BUF) + 1;

  // In side: protocol layer fills and commits buffers.
  logic [ADDR_W-1:0] buf_in_addr;
  logic [DATA_W-1:0] buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic              buf_in_commit_err;

  // Out side: application reads and arms (releases) buffers.
  logic [ADDR_W-1:0] buf_out_addr;
  logic [DATA_W-1:0] buf_out_q;
  logic [LEN_W-1:0]  buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic              buf_out_arm_err;

  // Status and configuration.
  logic              overrun;
  logic [CNT_W-1:0]  fill_count;
  logic [1:0]        mode;

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_out_addr, buf_out_arm, mode,
    output buf_in_ready, buf_in_commit_ack, buf_in_commit_err,
    output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, buf_out_arm_err,
    output overrun, fill_count
  );

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_out_addr, buf_out_arm, mode,
    input  buf_in_ready, buf_in_commit_ack, buf_in_commit_err,
    input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, buf_out_arm_err,
    input  overrun, fill_count
  );

endinterface

// File: rtl/usb3_ep_ram.sv
// Simple dual-port RAM, one clock, registered read. A read of the address
// being written in the same cycle returns the previous contents.
module usb3_ep_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port.
  // NOTE: the array and its read register carry no reset; clearing a RAM costs
  // a cycle per word and the ring never reads a slot before it was committed.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb3_ep_ring.sv
// N-deep buffer ring for a USB 3.0 endpoint. The in side fills the buffer at
// wr_ptr and commits it with a byte length; the out side reads the buffer at
// rd_ptr and arms it to release the slot. Isochronous commits into a full
// ring overwrite the oldest buffer. Define USB3_EP_RING_STATS_EN to add
// saturating 16-bit overrun / commit-error / arm-error counters.
module usb3_ep_ring
  import usb3_ep_pkg::*;
#(
  parameter int NUM_BUF   = NUM_BUF_DEF,
  parameter int BUF_WORDS = BUF_WORDS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic         local_clk,
  input  logic         reset_n,
  usb3_ep_ring_if.slave bus
`ifdef USB3_EP_RING_STATS_EN
  ,
  input  logic         stat_clr,
  output logic [15:0]  stat_overrun,
  output logic [15:0]  stat_commit_err,
  output logic [15:0]  stat_arm_err
`endif
);

  localparam int PTR_W     = clog2(NUM_BUF);
  localparam int ADDR_W    = clog2(BUF_WORDS);
  localparam int CNT_W     = PTR_W + 1;
  localparam int BUF_BYTES = BUF_WORDS * DATA_W / 8;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q [NUM_BUF];

  logic commit_ack_q, commit_ack_d;
  logic commit_err_q, commit_err_d;
  logic arm_ack_q,    arm_ack_d;
  logic arm_err_q,    arm_err_d;
  logic overrun_q,    overrun_d;

  logic             full, empty;
  logic             arm_ok, commit_take, commit_ovr, ram_we;
  logic [LEN_W-1:0] len_clamped;

  assign full  = (count_q == CNT_W'(NUM_BUF));
  assign empty = (count_q == '0);

  // Decide commit/arm outcomes from the pre-edge count, then form next state.
  // An arm that frees a slot lets a same-cycle commit into a full ring pass
  // without error or overwrite.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    arm_ok       = 1'b0;
    commit_take  = 1'b0;
    commit_ovr   = 1'b0;
    commit_err_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (bus.buf_out_arm && !empty) arm_ok = 1'b1;

    if (bus.buf_in_commit) begin
      if (!full || arm_ok)                   commit_take = 1'b1;
      else if (bus.mode == EP_MODE_ISOCH) begin
        commit_take = 1'b1;
        commit_ovr  = 1'b1;
      end else                               commit_err_d = 1'b1;
    end

    if (commit_take) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (arm_ok || commit_ovr) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(commit_take && !commit_ovr) - CNT_W'(arm_ok);

    commit_ack_d = commit_take;
    overrun_d    = commit_ovr;
    arm_ack_d    = arm_ok;
    arm_err_d    = bus.buf_out_arm && empty;
  end

  assign len_clamped = (bus.buf_in_commit_len > LEN_W'(BUF_BYTES)) ? LEN_W'(BUF_BYTES)
                                                                   : bus.buf_in_commit_len;

  // Ring pointers, fill count, per-buffer lengths and the one-cycle pulses.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < NUM_BUF; i++) len_q[i] <= '0;
      commit_ack_q <= 1'b0;
      commit_err_q <= 1'b0;
      arm_ack_q    <= 1'b0;
      arm_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (commit_take) len_q[wr_ptr_q] <= len_clamped;
      commit_ack_q <= commit_ack_d;
      commit_err_q <= commit_err_d;
      arm_ack_q    <= arm_ack_d;
      arm_err_q    <= arm_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Writes into a full ring are dropped unless isochronous overwrite applies.
  assign ram_we = bus.buf_in_wren && (!full || (bus.mode == EP_MODE_ISOCH));

  usb3_ep_ram #(
    .ADDR_W (PTR_W + ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (local_clk),
    .we_i    (ram_we),
    .waddr_i ({wr_ptr_q, bus.buf_in_addr}),
    .wdata_i (bus.buf_in_data),
    .raddr_i ({rd_ptr_q, bus.buf_out_addr}),
    .rdata_o (bus.buf_out_q)
  );

  assign bus.buf_in_ready      = !full;
  assign bus.buf_out_hasdata   = !empty;
  assign bus.buf_out_len       = len_q[rd_ptr_q];
  assign bus.fill_count        = count_q;
  assign bus.buf_in_commit_ack = commit_ack_q;
  assign bus.buf_in_commit_err = commit_err_q;
  assign bus.buf_out_arm_ack   = arm_ack_q;
  assign bus.buf_out_arm_err   = arm_err_q;
  assign bus.overrun           = overrun_q;

`ifdef USB3_EP_RING_STATS_EN
  logic [15:0] stat_ovr_q, stat_cerr_q, stat_aerr_q;

  // Saturating event counters fed by the output pulses; clear beats increment.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ovr_q  <= '0;
      stat_cerr_q <= '0;
      stat_aerr_q <= '0;
    end else if (stat_clr) begin
      stat_ovr_q  <= '0;
      stat_cerr_q <= '0;
      stat_aerr_q <= '0;
    end else begin
      stat_ovr_q  <= sat_inc16(stat_ovr_q,  overrun_q);
      stat_cerr_q <= sat_inc16(stat_cerr_q, commit_err_q);
      stat_aerr_q <= sat_inc16(stat_aerr_q, arm_err_q);
    end
  end

  assign stat_overrun    = stat_ovr_q;
  assign stat_commit_err = stat_cerr_q;
  assign stat_arm_err    = stat_aerr_q;
`endif

endmodule

// File: tb/tb_usb3_ep_ring.sv
// Self-checking bench for usb3_ep_ring: a directed vector table for the
// commit/arm/overwrite rules, hand sequences for data latency and async
// reset, then randomized traffic against a behavioural ring model.
module tb_usb3_ep_ring;

  localparam int NB        = 4;
  localparam int BW        = 256;
  localparam int DW        = 32;
  localparam int LW        = 11;
  localparam int BUF_BYTES = BW * DW / 8;

  logic local_clk = 1'b0;
  logic reset_n;
  always #5 local_clk = ~local_clk;

  usb3_ep_ring_if #(.NUM_BUF(NB), .BUF_WORDS(BW), .DATA_W(DW), .LEN_W(LW)) bus ();

`ifdef USB3_EP_RING_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_overrun, stat_commit_err, stat_arm_err;
`endif

  usb3_ep_ring #(.NUM_BUF(NB), .BUF_WORDS(BW), .DATA_W(DW), .LEN_W(LW)) dut (
    .local_clk (local_clk),
    .reset_n   (reset_n),
    .bus       (bus)
`ifdef USB3_EP_RING_STATS_EN
    ,
    .stat_clr        (stat_clr),
    .stat_overrun    (stat_overrun),
    .stat_commit_err (stat_commit_err),
    .stat_arm_err    (stat_arm_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; return just after the edge so outputs are settled.
  task automatic step();
    @(posedge local_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.buf_in_wren   = 1'b0;
    bus.buf_in_commit = 1'b0;
    bus.buf_out_arm   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  // Directed vector record: inputs for one cycle and outputs after its edge.
  typedef struct {
    bit       commit;
    int       len;
    bit       arm;
    bit [1:0] mode;
    bit       ack, err, aack, aerr, ovr;
    int       fill;
    int       out_len;
  } vec_t;

  vec_t vecs[25];

  // Behavioural ring model used for the randomized phase.
  int              m_wr, m_rd, m_cnt;
  int              m_len [NB];
  logic [DW-1:0]   m_mem [NB][BW];
  bit              m_vld [NB][BW];
  int              t_ovr, t_cerr, t_aerr;

  bit              r_c, r_a, r_w, r_full, r_empty, r_arm_ok;
  bit              e_ack, e_err, e_aack, e_aerr, e_ovr, q_vld;
  int              r_len, r_ia, r_oa, c_pct, a_pct;
  logic [1:0]      r_md;
  logic [DW-1:0]   r_d, q_exp;

  initial begin
    bus.buf_in_addr       = '0;
    bus.buf_in_data       = '0;
    bus.buf_in_commit_len = '0;
    bus.buf_out_addr      = '0;
    bus.mode              = 2'd2;
`ifdef USB3_EP_RING_STATS_EN
    stat_clr = 1'b0;
`endif
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) step();

    // Reset state, checked while reset is held.
    check("rst_fill",    bus.fill_count, 0);
    check("rst_ready",   bus.buf_in_ready, 1);
    check("rst_hasdata", bus.buf_out_hasdata, 0);
    check("rst_out_len", bus.buf_out_len, 0);
    check("rst_ack",     bus.buf_in_commit_ack, 0);
    check("rst_err",     bus.buf_in_commit_err, 0);
    check("rst_aack",    bus.buf_out_arm_ack, 0);
    check("rst_aerr",    bus.buf_out_arm_err, 0);
    check("rst_ovr",     bus.overrun, 0);
    reset_n = 1'b1;
    step();

    // commit, len, arm, mode | ack, err, aack, aerr, ovr | fill, out_len
    vecs[0]  = '{1, 512,  0, 2, 1, 0, 0, 0, 0, 1, 512};
    vecs[1]  = '{1, 100,  0, 2, 1, 0, 0, 0, 0, 2, 512};
    vecs[2]  = '{1, 1024, 0, 2, 1, 0, 0, 0, 0, 3, 512};
    vecs[3]  = '{1, 0,    0, 2, 1, 0, 0, 0, 0, 4, 512};
    vecs[4]  = '{1, 77,   0, 2, 0, 1, 0, 0, 0, 4, 512};
    vecs[5]  = '{0, 0,    0, 2, 0, 0, 0, 0, 0, 4, 512};
    vecs[6]  = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 3, 100};
    vecs[7]  = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 2, 1024};
    vecs[8]  = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 1, 0};
    vecs[9]  = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 0, 512};
    vecs[10] = '{0, 0,    1, 2, 0, 0, 0, 1, 0, 0, 512};
    vecs[11] = '{1, 64,   1, 2, 1, 0, 0, 1, 0, 1, 64};
    vecs[12] = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 0, 100};
    vecs[13] = '{1, 10,   0, 1, 1, 0, 0, 0, 0, 1, 10};
    vecs[14] = '{1, 20,   0, 1, 1, 0, 0, 0, 0, 2, 10};
    vecs[15] = '{1, 30,   0, 1, 1, 0, 0, 0, 0, 3, 10};
    vecs[16] = '{1, 40,   0, 1, 1, 0, 0, 0, 0, 4, 10};
    vecs[17] = '{1, 50,   0, 1, 1, 0, 0, 0, 1, 4, 20};
    vecs[18] = '{1, 60,   1, 2, 1, 0, 1, 0, 0, 4, 30};
    vecs[19] = '{1, 70,   1, 2, 1, 0, 1, 0, 0, 4, 40};
    vecs[20] = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 3, 50};
    vecs[21] = '{1, 2047, 0, 2, 1, 0, 0, 0, 0, 4, 50};
    vecs[22] = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 3, 60};
    vecs[23] = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 2, 70};
    vecs[24] = '{0, 0,    1, 2, 0, 0, 1, 0, 0, 1, 1024};

    for (int i = 0; i < 25; i++) begin
      bus.buf_in_commit     = vecs[i].commit;
      bus.buf_in_commit_len = LW'(vecs[i].len);
      bus.buf_out_arm       = vecs[i].arm;
      bus.mode              = vecs[i].mode;
      step();
      idle_inputs();
      check($sformatf("v%0d_ack", i),     bus.buf_in_commit_ack, vecs[i].ack);
      check($sformatf("v%0d_err", i),     bus.buf_in_commit_err, vecs[i].err);
      check($sformatf("v%0d_aack", i),    bus.buf_out_arm_ack, vecs[i].aack);
      check($sformatf("v%0d_aerr", i),    bus.buf_out_arm_err, vecs[i].aerr);
      check($sformatf("v%0d_ovr", i),     bus.overrun, vecs[i].ovr);
      check($sformatf("v%0d_fill", i),    bus.fill_count, vecs[i].fill);
      check($sformatf("v%0d_outlen", i),  bus.buf_out_len, vecs[i].out_len);
      check($sformatf("v%0d_ready", i),   bus.buf_in_ready, vecs[i].fill != NB);
      check($sformatf("v%0d_hasdata", i), bus.buf_out_hasdata, vecs[i].fill != 0);
    end

    // Data path: write a word into buffer 0, commit, read it back.
    do_reset();
    bus.mode         = 2'd2;
    bus.buf_in_addr  = 8'd3;
    bus.buf_in_data  = 32'h0000_00A5;
    bus.buf_in_wren  = 1'b1;
    step();
    bus.buf_in_wren       = 1'b0;
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = 11'd4;
    step();
    bus.buf_in_commit = 1'b0;
    check("data_commit_ack", bus.buf_in_commit_ack, 1);
    bus.buf_out_addr = 8'd3;
    step();
    check("data_q", bus.buf_out_q, 32'h0000_00A5);

    // Asynchronous reset mid-stream with three buffers held.
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = 11'd8;
    repeat (2) step();
    bus.buf_in_commit = 1'b0;
    check("pre_rst_fill", bus.fill_count, 3);
    check("pre_rst_ack",  bus.buf_in_commit_ack, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_fill",    bus.fill_count, 0);
    check("async_rst_hasdata", bus.buf_out_hasdata, 0);
    check("async_rst_ready",   bus.buf_in_ready, 1);
    check("async_rst_ack",     bus.buf_in_commit_ack, 0);
    step();
    reset_n = 1'b1;

    // Over-long commit length saturates to the buffer size.
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = 11'd2047;
    step();
    bus.buf_in_commit = 1'b0;
    check("sat_len", bus.buf_out_len, BUF_BYTES);
    check("sat_fill", bus.fill_count, 1);

    // Randomized traffic against the model, from a fresh reset.
    do_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0;
    t_ovr = 0; t_cerr = 0; t_aerr = 0;
    for (int b = 0; b < NB; b++) begin
      m_len[b] = 0;
      for (int w = 0; w < BW; w++) m_vld[b][w] = 1'b0;
    end
    r_md = 2'd1;

    for (int i = 0; i < 3000; i++) begin
      if ((i / 200) % 2 == 0) begin c_pct = 60; a_pct = 30; end
      else                    begin c_pct = 30; a_pct = 60; end
      if (i % 20 == 0) r_md = $urandom_range(0, 1) ? 2'd1 : 2'($urandom_range(0, 3));
      r_c   = ($urandom_range(0, 99) < c_pct);
      r_a   = ($urandom_range(0, 99) < a_pct);
      r_w   = ($urandom_range(0, 99) < 60);
      r_len = $urandom_range(0, 2047);
      r_ia  = $urandom_range(0, 7);
      r_oa  = $urandom_range(0, 7);
      r_d   = $urandom;

      bus.buf_in_commit     = r_c;
      bus.buf_in_commit_len = LW'(r_len);
      bus.buf_out_arm       = r_a;
      bus.buf_in_wren       = r_w;
      bus.buf_in_addr       = 8'(r_ia);
      bus.buf_in_data       = r_d;
      bus.buf_out_addr      = 8'(r_oa);
      bus.mode              = r_md;

      // Expected outcome from the ring rules, on the pre-edge fill level.
      r_full   = (m_cnt == NB);
      r_empty  = (m_cnt == 0);
      r_arm_ok = r_a && !r_empty;
      e_aack   = r_arm_ok;
      e_aerr   = r_a && r_empty;
      e_ack = 0; e_err = 0; e_ovr = 0;
      if (r_c) begin
        if (!r_full || r_arm_ok) e_ack = 1;
        else if (r_md == 2'd1) begin e_ack = 1; e_ovr = 1; end
        else e_err = 1;
      end
      q_vld = m_vld[m_rd][r_oa];
      q_exp = m_mem[m_rd][r_oa];
      if (r_w && (!r_full || r_md == 2'd1)) begin
        m_mem[m_wr][r_ia] = r_d;
        m_vld[m_wr][r_ia] = 1'b1;
      end
      if (e_ack) begin
        m_len[m_wr] = (r_len > BUF_BYTES) ? BUF_BYTES : r_len;
        m_wr = (m_wr + 1) % NB;
        if (e_ovr) m_rd = (m_rd + 1) % NB;
        else       m_cnt++;
      end
      if (r_arm_ok) begin
        m_rd = (m_rd + 1) % NB;
        m_cnt--;
      end
      t_ovr  += int'(e_ovr);
      t_cerr += int'(e_err);
      t_aerr += int'(e_aerr);

      step();
      check("rnd_ack",     bus.buf_in_commit_ack, e_ack);
      check("rnd_err",     bus.buf_in_commit_err, e_err);
      check("rnd_aack",    bus.buf_out_arm_ack, e_aack);
      check("rnd_aerr",    bus.buf_out_arm_err, e_aerr);
      check("rnd_ovr",     bus.overrun, e_ovr);
      check("rnd_fill",    bus.fill_count, m_cnt);
      check("rnd_ready",   bus.buf_in_ready, m_cnt != NB);
      check("rnd_hasdata", bus.buf_out_hasdata, m_cnt != 0);
      check("rnd_outlen",  bus.buf_out_len, m_len[m_rd]);
      if (q_vld) check("rnd_q", bus.buf_out_q, q_exp);
    end
    idle_inputs();
    repeat (2) step();

`ifdef USB3_EP_RING_STATS_EN
    check("stat_overrun",    stat_overrun, t_ovr);
    check("stat_commit_err", stat_commit_err, t_cerr);
    check("stat_arm_err",    stat_arm_err, t_aerr);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("stat_clr", stat_overrun, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
